// File: rtl/bpf_stage0_fetch_if.sv
// Fetch-stage bundle: control inputs, instruction-memory port and the
// valid/ready handshake towards decode. master = fetch stage, slave = environment.
interface bpf_stage0_fetch_if #(
  parameter int PC_WIDTH    = 10,
  parameter int COUNT_WIDTH = 6
);
  logic                   start;
  logic                   halt;
  logic                   branch_mispredict;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    inst_rd_addr;
  logic                   inst_rd_en;
  logic [63:0]            inst_mem_data;
  logic [63:0]            instr_out;
  logic [PC_WIDTH-1:0]    pc_out;
  logic                   PC_en;
  logic [COUNT_WIDTH-1:0] ocount;
  logic                   vld;
  logic                   next_rdy;

  modport master (
    input  start, halt, branch_mispredict, branch_target, inst_mem_data, PC_en, next_rdy,
    output inst_rd_addr, inst_rd_en, instr_out, pc_out, ocount, vld
  );

  modport slave (
    output start, halt, branch_mispredict, branch_target, inst_mem_data, PC_en, next_rdy,
    input  inst_rd_addr, inst_rd_en, instr_out, pc_out, ocount, vld
  );
endinterface

// File: rtl/bpf_stage0_fetch.sv
// BPF CPU fetch stage: PC sequencing, one-deep outstanding memory read and a
// 2-entry output buffer that absorbs decode back-pressure without loss.
module bpf_stage0_fetch #(
  parameter int PC_WIDTH    = 10,
  parameter int COUNT_WIDTH = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  bpf_stage0_fetch_if.master   fetch
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
  logic                   r_inflight;
  logic [PC_WIDTH-1:0]    r_inflight_pc;
  logic [1:0]             r_occ;

  logic [63:0]            r_instr [2];
  logic [PC_WIDTH-1:0]    r_epc   [2];
  logic [COUNT_WIDTH-1:0] r_cnt   [2];

  logic                   w_run, w_flush, w_pop, w_push, w_issue, w_vld;
  logic [2:0]             w_slots;
  logic [1:0]             w_occ_after_pop;

  assign w_run           = (r_state == S_RUN);
  assign w_vld           = (r_occ != 2'd0);
  assign w_flush         = w_run && (fetch.halt || fetch.branch_mispredict);
  assign w_pop           = w_vld && fetch.next_rdy;
  // Data returning during a flush belongs to the abandoned path.
  assign w_push          = r_inflight && !w_flush;
  assign w_slots         = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue         = w_run && !fetch.halt && !fetch.branch_mispredict && (w_slots < 3'd2);
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    fetch.inst_rd_en   = w_issue;
    fetch.inst_rd_addr = r_pc;
    case (r_state)
      S_IDLE: begin
        if (fetch.start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
        end
      end
      S_RUN: begin
        if (fetch.halt) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end else if (fetch.branch_mispredict) begin
          w_pc_nxt = fetch.branch_target;
        end else if (w_issue) begin
          w_pc_nxt = r_pc + PC_WIDTH'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_occ         <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      r_occ <= w_flush ? 2'd0 : (w_occ_after_pop + {1'b0, w_push});
    end
  end

  // Buffer is a shift pair: entry 0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer entries are reset because the head drives outputs that must read 0 out of reset.
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_epc[i]   <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      if (w_pop) begin
        r_instr[0] <= r_instr[1];
        r_epc[0]   <= r_epc[1];
        r_cnt[0]   <= r_cnt[1];
      end else if (w_vld && fetch.PC_en && (r_cnt[0] != '1)) begin
        r_cnt[0] <= r_cnt[0] + COUNT_WIDTH'(1);
      end
      // A later write to the same slot overrides the shift above.
      if (w_push) begin
        r_instr[w_occ_after_pop[0]] <= fetch.inst_mem_data;
        r_epc[w_occ_after_pop[0]]   <= r_inflight_pc;
        r_cnt[w_occ_after_pop[0]]   <= '0;
      end
    end
  end

  assign fetch.vld       = w_vld;
  assign fetch.instr_out = r_instr[0];
  assign fetch.pc_out    = r_epc[0];
  assign fetch.ocount    = r_cnt[0];

endmodule

// File: tb/tb_bpf_stage0_fetch.sv
// Randomised bench for bpf_stage0_fetch against a queue-based reference model
// of the fetch rules, plus directed back-pressure, redirect, wrap and reset cases.
module tb_bpf_stage0_fetch;
  localparam int PW   = 10;
  localparam int CW   = 6;
  localparam int NPC  = 1 << PW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bpf_stage0_fetch_if #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) bus ();

  bpf_stage0_fetch #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fetch (bus)
  );

  logic [63:0] mem [NPC];
  always @(posedge clk) if (bus.inst_rd_en) bus.inst_mem_data <= mem[bus.inst_rd_addr];

  typedef struct {
    logic [63:0] instr;
    int          pc;
    int          cnt;
  } ent_t;

  ent_t q[$];
  bit   m_run;
  int   m_pc;
  bit   m_infl;
  int   m_infl_pc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_run = 0; m_pc = 0; m_infl = 0; m_infl_pc = 0;
  endfunction

  function automatic bit model_issue(bit hl, bit bm, bit rdy);
    int pop = (q.size() > 0 && rdy) ? 1 : 0;
    return m_run && !hl && !bm && (q.size() + int'(m_infl) - pop < 2);
  endfunction

  function automatic void model_clock(bit st, bit hl, bit bm, int tgt, bit rdy, bit pe);
    bit pop   = (q.size() > 0) && rdy;
    bit iss   = model_issue(hl, bm, rdy);
    bit flush = m_run && (hl || bm);
    ent_t e;
    if (pop) void'(q.pop_front());
    else if (q.size() > 0 && pe && q[0].cnt < CMAX) q[0].cnt++;
    if (flush) q.delete();
    if (m_infl && !flush) begin
      e.instr = mem[m_infl_pc];
      e.pc    = m_infl_pc;
      e.cnt   = 0;
      q.push_back(e);
    end
    m_infl = iss;
    if (iss) m_infl_pc = m_pc;
    if (!m_run) begin
      if (st) begin m_run = 1; m_pc = 0; end
    end else if (hl) begin
      m_run = 0; m_pc = 0;
    end else if (bm) begin
      m_pc = tgt;
    end else if (iss) begin
      m_pc = (m_pc + 1) % NPC;
    end
  endfunction

  task automatic compare_outputs(input bit hl, input bit bm, input bit rdy);
    bit exp_vld = q.size() > 0;
    bit exp_iss = model_issue(hl, bm, rdy);
    check("vld", 64'(bus.vld), 64'(exp_vld));
    if (exp_vld) begin
      check("instr_out", bus.instr_out, q[0].instr);
      check("pc_out", 64'(bus.pc_out), 64'(q[0].pc));
      check("ocount", 64'(bus.ocount), 64'(q[0].cnt));
    end
    check("inst_rd_en", 64'(bus.inst_rd_en), 64'(exp_iss));
    if (exp_iss) check("inst_rd_addr", 64'(bus.inst_rd_addr), 64'(m_pc));
  endtask

  task automatic step(input bit st, input bit hl, input bit bm, input int tgt,
                      input bit rdy, input bit pe);
    @(negedge clk);
    bus.start             = st;
    bus.halt              = hl;
    bus.branch_mispredict = bm;
    bus.branch_target     = PW'(tgt);
    bus.next_rdy          = rdy;
    bus.PC_en             = pe;
    #1;
    compare_outputs(hl, bm, rdy);
    @(posedge clk);
    model_clock(st, hl, bm, tgt, rdy, pe);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},     64'(bus.vld), 64'd0);
    check({tag, "_rd_en"},   64'(bus.inst_rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(bus.inst_rd_addr), 64'd0);
    check({tag, "_instr"},   bus.instr_out, 64'd0);
    check({tag, "_pc_out"},  64'(bus.pc_out), 64'd0);
    check({tag, "_ocount"},  64'(bus.ocount), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NPC; i++) mem[i] = 64'(i) * 64'h0101;
    bus.inst_mem_data     = '0;
    bus.start             = 0;
    bus.halt              = 0;
    bus.branch_mispredict = 0;
    bus.branch_target     = '0;
    bus.next_rdy          = 0;
    bus.PC_en             = 0;
    model_reset();

    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle without start: nothing fetched.
    repeat (3) step(0, 0, 0, 0, 1, 0);

    // Streaming with decode always ready.
    step(1, 0, 0, 0, 1, 0);
    repeat (8) step(0, 0, 0, 0, 1, 0);

    // Back-pressure for 5 cycles with PC_en, then resume.
    repeat (5) step(0, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1, 1);

    // Redirect to 0x40 while buffer full, then with a read in flight.
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 'h40, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 'h40, 1, 0);
    repeat (5) step(0, 0, 0, 0, 1, 0);

    // PC wrap at the top of the address space.
    step(0, 0, 1, NPC - 2, 1, 0);
    repeat (7) step(0, 0, 0, 0, 1, 0);

    // ocount saturation under long back-pressure.
    repeat (CMAX + 6) step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1, 1);

    // halt and mispredict together: halt wins; start is ignored in RUN beforehand.
    step(1, 0, 0, 0, 1, 0);
    step(0, 1, 1, 5, 1, 0);
    repeat (4) step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 20) == 0, ($urandom % 200) == 0, ($urandom % 40) == 0,
           int'($urandom % NPC), ($urandom % 4) != 0, $urandom % 2);
    end

    // Asynchronous reset mid-stream.
    step(1, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    check("pre_reset_vld", 64'(bus.vld), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
